channel_arbiter: RTL and testbench

CHANNEL_ARBITER -- requirements
Module: channel_arbiter

---
 rtl/channel_pkg.sv | 25 ++
 rtl/channel_rr_pick.sv | 43 ++++
 rtl/channel_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_channel_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/channel_pkg.sv
// ----------------------------------------------------------------------------
// channel_pkg -- shared types and constants for the channel arbiter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package channel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_START       = 3'd1,
    ST_WAIT_ACTIVE = 3'd2,
    ST_BUSY        = 3'd3,
    ST_DONE        = 3'd4
  } state_e;

  localparam int STATUS_DE_BIT  = 5;
  localparam int STATUS_CE_BIT  = 4;

  localparam int FLAG_NO_STATUS = 0;
  localparam int FLAG_TIMEOUT   = 1;

endpackage

`default_nettype wire

// File: rtl/channel_rr_pick.sv
// ----------------------------------------------------------------------------
// channel_rr_pick -- combinational round-robin pick, search starts after last.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module channel_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic               any_o,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  int               cand;
  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    any_o       = 1'b0;
    grant_o     = '0;
    grant_idx_o = '0;
    cand        = 0;
    idx         = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = int'(last_grant_i) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      idx = cand[IDX_W-1:0];
      if (req_i[idx]) begin
        any_o       = 1'b1;
        grant_o     = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/channel_arbiter.sv
// ----------------------------------------------------------------------------
// channel_arbiter -- round-robin owner of a shared channel; optional busy
// watchdog enabled by CHANNEL_ARB_TIMEOUT_EN.   Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module channel_arbiter
  import channel_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_command,
  input  logic [NUM_REQ-1:0]   req_stop,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           done_status,
  output logic [1:0]           done_flags,
  output logic [7:0]           chan_addr,
  output logic [7:0]           chan_command,
  output logic                 chan_start,
  output logic                 chan_stop,
  input  logic                 chan_active,
  input  logic [7:0]           chan_status_tdata,
  input  logic                 chan_status_tvalid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("channel_arbiter: parameter out of range");
  end

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [7:0]         addr_q, addr_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [7:0]         status_q, status_d;
  logic               seen_q, seen_d;
  logic               stop_prev_q;
  logic               chan_stop_q, chan_stop_d;
  logic [7:0]         done_status_q, done_status_d;
  logic               nostat_q, nostat_d;

  logic               pick_any;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [7:0]         sel_addr, sel_cmd;
  logic               owner_stop;

`ifdef CHANNEL_ARB_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             done_to_q, done_to_d;
`endif

  channel_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i        (req_valid),
    .last_grant_i (last_q),
    .any_o        (pick_any),
    .grant_o      (pick_grant),
    .grant_idx_o  (pick_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_cmd  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr = req_addr[8*i +: 8];
        sel_cmd  = req_command[8*i +: 8];
      end
    end
  end

  assign owner_stop = |(req_stop & grant_q);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_d        = last_q;
    addr_d        = addr_q;
    cmd_d         = cmd_q;
    status_d      = status_q;
    seen_d        = seen_q;
    chan_stop_d   = 1'b0;
    done_status_d = done_status_q;
    nostat_d      = nostat_q;
`ifdef CHANNEL_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
    to_d          = to_q;
    done_to_d     = done_to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_START;
          grant_d = pick_grant;
          owner_d = pick_idx;
          addr_d  = sel_addr;
          cmd_d   = sel_cmd;
        end
      end
      ST_START: state_d = ST_WAIT_ACTIVE;
      ST_WAIT_ACTIVE: begin
        if (chan_active) begin
          state_d  = ST_BUSY;
          status_d = '0;
          seen_d   = 1'b0;
`ifdef CHANNEL_ARB_TIMEOUT_EN
          cnt_d    = '0;
          to_d     = 1'b0;
`endif
        end
      end
      ST_BUSY: begin
        if (chan_status_tvalid) begin
          status_d = chan_status_tdata;
          seen_d   = 1'b1;
        end
        if (owner_stop && !stop_prev_q) chan_stop_d = 1'b1;
`ifdef CHANNEL_ARB_TIMEOUT_EN
        // Counter saturates at the limit so the watchdog stop fires only once.
        if (cnt_q != TO_LIMIT) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == TO_LIMIT && chan_active) begin
            chan_stop_d = 1'b1;
            to_d        = 1'b1;
          end
        end
`endif
        if (!chan_active) begin
          state_d       = ST_DONE;
          done_status_d = status_d;
          nostat_d      = !seen_d;
`ifdef CHANNEL_ARB_TIMEOUT_EN
          done_to_d     = to_d;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        last_d  = owner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      last_q        <= IDX_W'(NUM_REQ - 1);
      addr_q        <= '0;
      cmd_q         <= '0;
      status_q      <= '0;
      seen_q        <= 1'b0;
      stop_prev_q   <= 1'b0;
      chan_stop_q   <= 1'b0;
      done_status_q <= '0;
      nostat_q      <= 1'b0;
`ifdef CHANNEL_ARB_TIMEOUT_EN
      cnt_q         <= '0;
      to_q          <= 1'b0;
      done_to_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      addr_q        <= addr_d;
      cmd_q         <= cmd_d;
      status_q      <= status_d;
      seen_q        <= seen_d;
      stop_prev_q   <= owner_stop;
      chan_stop_q   <= chan_stop_d;
      done_status_q <= done_status_d;
      nostat_q      <= nostat_d;
`ifdef CHANNEL_ARB_TIMEOUT_EN
      cnt_q         <= cnt_d;
      to_q          <= to_d;
      done_to_q     <= done_to_d;
`endif
    end
  end

  assign grant        = grant_q;
  assign done         = (state_q == ST_DONE) ? grant_q : '0;
  assign chan_start   = (state_q == ST_START);
  assign chan_stop    = chan_stop_q;
  assign chan_addr    = addr_q;
  assign chan_command = cmd_q;
  assign done_status  = done_status_q;
  assign done_flags[FLAG_NO_STATUS] = nostat_q;
`ifdef CHANNEL_ARB_TIMEOUT_EN
  assign done_flags[FLAG_TIMEOUT]   = done_to_q;
`else
  assign done_flags[FLAG_TIMEOUT]   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_channel_arbiter.sv
// ----------------------------------------------------------------------------
// tb_channel_arbiter -- directed bench with a cycle-level reference model.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_channel_arbiter;

  localparam int N = 4;
`ifdef CHANNEL_ARB_TIMEOUT_EN
  localparam int TO = 16;
  localparam logic [1:0] T1_FLAGS = 2'b10;
`else
  localparam int TO = 1024;
  localparam logic [1:0] T1_FLAGS = 2'b00;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_stop  = '0;
  logic [8*N-1:0] req_addr    = {8'h40, 8'h30, 8'h20, 8'h10};
  logic [8*N-1:0] req_command = {8'h08, 8'h06, 8'h04, 8'h02};
  logic           chan_active = 1'b0;
  logic           tvalid = 1'b0;
  logic [7:0]     tdata  = '0;
  wire  [N-1:0]   grant, done;
  wire  [7:0]     done_status, chan_addr, chan_command;
  wire  [1:0]     done_flags;
  wire            chan_start, chan_stop;

  always #5 clk = ~clk;

  channel_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_command(req_command), .req_stop(req_stop), .grant(grant), .done(done),
    .done_status(done_status), .done_flags(done_flags), .chan_addr(chan_addr),
    .chan_command(chan_command), .chan_start(chan_start), .chan_stop(chan_stop),
    .chan_active(chan_active), .chan_status_tdata(tdata), .chan_status_tvalid(tvalid)
  );

  int checks = 0, errors = 0;
  int n_start = 0, n_stop = 0, n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr(input int lst, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(lst + k) % N]) return (lst + k) % N;
    end
    return -1;
  endfunction

  // Reference model: phase 0 idle, 1 start, 2 wait-active, 3 busy, 4 done.
  int           ph, owner, last, bcnt;
  logic [7:0]   m_addr, m_cmd, st_val, h_status;
  logic [1:0]   h_flags;
  logic         st_seen, m_to, own_prev, own_now, stop_exp;
  logic [N-1:0] s_valid, s_stop, e_grant;
  logic [7:0]   s_data;
  logic         s_active, s_tvalid;

  always @(negedge clk) begin
    if (rst) begin
      ph = 0; owner = -1; last = N - 1; bcnt = 0;
      m_addr = 0; m_cmd = 0; st_val = 0; h_status = 0; h_flags = 0;
      st_seen = 0; m_to = 0; own_prev = 0;
      chk("reset_outputs", {grant, done, chan_start, chan_stop, chan_addr,
                            chan_command, done_status, done_flags}, 32'h0);
    end else begin
      stop_exp = 1'b0;
      own_now  = (ph != 0) ? s_stop[owner] : 1'b0;
      case (ph)
        0: begin
          owner = rr(last, s_valid);
          if (owner >= 0) begin
            ph = 1;
            m_addr = req_addr[8*owner +: 8];
            m_cmd  = req_command[8*owner +: 8];
          end
        end
        1: ph = 2;
        2: if (s_active) begin ph = 3; st_val = 0; st_seen = 0; bcnt = 0; m_to = 0; end
        3: begin
          if (s_tvalid) begin st_val = s_data; st_seen = 1; end
          if (own_now && !own_prev) stop_exp = 1;
`ifdef CHANNEL_ARB_TIMEOUT_EN
          bcnt++;
          if (bcnt == TO && s_active) begin stop_exp = 1; m_to = 1; end
`endif
          if (!s_active) begin ph = 4; h_status = st_val; h_flags = {m_to, !st_seen}; end
        end
        default: begin last = owner; owner = -1; ph = 0; end
      endcase
      own_prev = own_now;
      e_grant = '0;
      if (ph != 0) e_grant[owner] = 1'b1;
      chk("grant", grant, e_grant);
      chk("done", done, (ph == 4) ? e_grant : '0);
      chk("chan_start", chan_start, ph == 1);
      chk("chan_stop", chan_stop, stop_exp);
      chk("chan_addr", chan_addr, m_addr);
      chk("chan_command", chan_command, m_cmd);
      chk("done_status", done_status, h_status);
      chk("done_flags", done_flags, h_flags);
      n_start += int'(chan_start);
      n_stop  += int'(chan_stop);
      n_done  += int'(done != '0);
    end
    s_valid = req_valid; s_stop = req_stop; s_active = chan_active;
    s_tvalid = tvalid; s_data = tdata;
  end

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_stop = '0; chan_active = 0; tvalid = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    while (chan_start !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk(nm, chan_start, 1'b1);
  endtask

  // One channel operation: active for len cycles after dly, optional status
  // at cycle st_at and a 3-cycle req_stop window starting at cycle stop_at.
  task automatic chan_op(input int dly, input int len, input int st_at, input logic [7:0] st_v,
                         input int stop_at, input logic [N-1:0] stop_v, input logic [N-1:0] valid_after,
                         output logic [N-1:0] g, output logic [7:0] ga, output logic [7:0] gc,
                         output logic [N-1:0] d, output logic [7:0] ds, output logic [1:0] df,
                         output int stop_c);
    int n;
    stop_c = -1; d = '0;
    wait_start("op_start_seen");
    g = grant; ga = chan_addr; gc = chan_command;
    @(posedge clk); #1;
    req_valid = valid_after;
    repeat (dly) begin @(posedge clk); #1; end
    for (int c = 0; c <= len; c++) begin
      chan_active = (c < len);
      tvalid      = (c == st_at);
      tdata       = (c == st_at) ? st_v : 8'h00;
      req_stop    = (stop_at >= 0 && c >= stop_at && c < stop_at + 3) ? stop_v : '0;
      @(negedge clk);
      if (chan_stop === 1'b1 && stop_c < 0) stop_c = c;
      @(posedge clk); #1;
    end
    chan_active = 0; tvalid = 0; req_stop = '0;
    n = 0;
    while (done === '0 && n < 10) begin @(negedge clk); n++; end
    d = done; ds = done_status; df = done_flags;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    logic [N-1:0] g, d;
    logic [7:0]   ga, gc, ds;
    logic [1:0]   df;
    int           sc, s0, nd;
    int           ord[5] = '{0, 1, 2, 3, 0};

    // Single request, status 0x0C mid-operation.
    do_reset();
    req_valid = 4'b0001; s0 = n_start;
    chan_op(1, 20, 7, 8'h0C, -1, '0, '0, g, ga, gc, d, ds, df, sc);
    chk("t1_grant", g, 4'b0001);
    chk("t1_addr", ga, 8'h10);
    chk("t1_cmd", gc, 8'h02);
    chk("t1_done", d, 4'b0001);
    chk("t1_status", ds, 8'h0C);
    chk("t1_flags", df, T1_FLAGS);
    chk("t1_starts", n_start - s0, 1);

    // All requesting: round-robin order from reset.
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      chan_op(0, 4, 2, 8'h10 + 8'(k), -1, '0, 4'b1111, g, ga, gc, d, ds, df, sc);
      if (k == 4) req_valid = '0;
      chk("t2_order", g, 4'b0001 << ord[k]);
      chk("t2_done", d, g);
      chk("t2_status", ds, 8'h10 + 8'(k));
    end

    // Owner 2 and requester 1 raise stop together; no status seen.
    do_reset();
    req_valid = 4'b0100; s0 = n_stop;
    chan_op(0, 12, -1, 8'h00, 4, 4'b0110, '0, g, ga, gc, d, ds, df, sc);
    chk("t3_grant", g, 4'b0100);
    chk("t3_stop_count", n_stop - s0, 1);
    chk("t3_stop_cycle", sc, 5);
    chk("t3_flags", df, 2'b01);

    // Non-owner stop only: ignored.
    req_valid = 4'b0100; s0 = n_stop;
    chan_op(0, 12, 3, 8'h55, 4, 4'b1011, '0, g, ga, gc, d, ds, df, sc);
    chk("t3b_stop_count", n_stop - s0, 0);
    chk("t3b_status", ds, 8'h55);

    // Active then inactive with no status.
    req_valid = 4'b0001;
    chan_op(2, 6, -1, 8'h00, -1, '0, '0, g, ga, gc, d, ds, df, sc);
    chk("t4_grant", g, 4'b0001);
    chk("t4_flags", df, 2'b01);

    // Status in the same cycle the channel goes inactive.
    req_valid = 4'b0001;
    chan_op(0, 6, 6, 8'hA5, -1, '0, '0, g, ga, gc, d, ds, df, sc);
    chk("t4b_status", ds, 8'hA5);
    chk("t4b_flags", df, 2'b00);

    // Reset while busy: immediate release, no done, restart at requester 0.
    do_reset();
    req_valid = 4'b0010;
    chan_op(0, 3, -1, 8'h00, -1, '0, '0, g, ga, gc, d, ds, df, sc);
    chk("t5_first", g, 4'b0010);
    req_valid = 4'b0100;
    wait_start("t5_start");
    chk("t5_owner", grant, 4'b0100);
    @(posedge clk); #1;
    req_valid = 4'b1111; chan_active = 1;
    repeat (4) begin @(posedge clk); #1; end
    chk("t5_busy_grant", grant, 4'b0100);
    nd = n_done;
    rst = 1'b1;
    #1;
    chk("t5_rst_grant", grant, 4'b0000);
    chk("t5_rst_done", done, 4'b0000);
    chan_active = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wait_start("t5_restart");
    chk("t5_next_grant", grant, 4'b0001);
    chk("t5_no_done", n_done - nd, 0);

`ifdef CHANNEL_ARB_TIMEOUT_EN
    // Watchdog: active held 40 cycles; stop when the busy counter reaches 16,
    // i.e. busy cycle 16 counting the first busy cycle as 0 (channel cycle 17).
    do_reset();
    req_valid = 4'b0001; s0 = n_stop;
    chan_op(0, 40, 5, 8'h33, -1, '0, '0, g, ga, gc, d, ds, df, sc);
    chk("t6_stop_cycle", sc, 17);
    chk("t6_stop_count", n_stop - s0, 1);
    chk("t6_flags", df, 2'b10);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
